decode_unit: RTL and testbench

- Registered, parametrised RV32I decode stage with valid/ready handshakes on both sides. It sits between the fetch/IR latch and the execute/ALU-decoder stage.
- Extracts opcode, funct3, funct7, rs1, rs2 and rd, and generates the sign-extended immediate for every format (I/S/B/U/J).
- Flags illegal opcodes.
- Holds a register scoreboard, so that no instruction is issued downstream while one of its source registers has a pending write.

---
 rtl/decode_unit_pkg.sv | 99 +++++++++
 rtl/decode_unit_imm_gen.sv | 27 ++
 rtl/decode_unit.sv | 132 +++++++++++++
 tb/tb_decode_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_unit_pkg.sv
// Shared types for the RV32I decode stage: opcode constants, immediate selector,
// the decoded field bundle and the FSM state encoding, plus the field decoder.
// Used by decode_unit and decode_unit_imm_gen.
package decode_unit_pkg;

  localparam logic [6:0] RType       = 7'b0110011;
  localparam logic [6:0] IType_logic = 7'b0010011;
  localparam logic [6:0] IType_load  = 7'b0000011;
  localparam logic [6:0] IType_jalr  = 7'b1100111;
  localparam logic [6:0] SType       = 7'b0100011;
  localparam logic [6:0] BType       = 7'b1100011;
  localparam logic [6:0] UType_lui   = 7'b0110111;
  localparam logic [6:0] UType_auipc = 7'b0010111;
  localparam logic [6:0] JType       = 7'b1101111;

  typedef logic [31:0] imm_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_VALID
  } dec_state_t;

  // Register fields are kept at their raw 5-bit instruction width here and
  // resized to the configured index width in the top level.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       illegal;
  } decode_bundle_t;

  function automatic imm_sel_t imm_sel_of(input logic [6:0] opcode);
    case (opcode)
      IType_logic, IType_load, IType_jalr: return IMM_I;
      SType:                               return IMM_S;
      BType:                               return IMM_B;
      UType_lui, UType_auipc:              return IMM_U;
      JType:                               return IMM_J;
      default:                             return IMM_NONE;
    endcase
  endfunction

  // Fields a format does not use are forced to zero so downstream never sees
  // stale bits from immediate slices.
  function automatic decode_bundle_t decode_instr(input logic [31:0] instr);
    decode_bundle_t d;
    d = '0;
    d.opcode = instr[6:0];
    case (instr[6:0])
      RType: begin
        d.funct3    = instr[14:12];
        d.funct7    = instr[31:25];
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        d.rd        = instr[11:7];
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
        d.writes_rd = 1'b1;
      end
      IType_logic, IType_load, IType_jalr: begin
        d.funct3    = instr[14:12];
        d.rs1       = instr[19:15];
        d.rd        = instr[11:7];
        d.uses_rs1  = 1'b1;
        d.writes_rd = 1'b1;
      end
      SType, BType: begin
        d.funct3    = instr[14:12];
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
      end
      UType_lui, UType_auipc, JType: begin
        d.rd        = instr[11:7];
        d.writes_rd = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_unit_imm_gen.sv
// Immediate generator: builds the sign-extended immediate for the selected format.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: instr[31:7] (opcode bits are not needed), imm_sel format, imm XLEN result.
module decode_unit_imm_gen
  import decode_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_sel_t        imm_sel,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage: one holding register plus a register-busy scoreboard.
// Latency: 1 cycle from input handshake to out_valid when no source is busy.
// Backpressure: in_ready only in IDLE or VALID&&out_ready; held bundle stable while stalled.
// Ports: clk/reset (sync, active-low); in_* request side; out_* decoded bundle;
//        wb_valid/wb_rd retire a pending write; flush drops the held instruction.
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int NUM_REGS        = 32,
  parameter int FLUSH_CLEARS_SB = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_instr,
  input  logic [XLEN-1:0]             in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_pc,
  output logic [6:0]                  out_opcode,
  output logic [2:0]                  out_funct3,
  output logic [6:0]                  out_funct7,
  output logic [$clog2(NUM_REGS)-1:0] out_rs1,
  output logic [$clog2(NUM_REGS)-1:0] out_rs2,
  output logic [$clog2(NUM_REGS)-1:0] out_rd,
  output logic [XLEN-1:0]             out_imm,
  output logic                        out_uses_rs1,
  output logic                        out_uses_rs2,
  output logic                        out_writes_rd,
  output logic                        out_illegal,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
  input  logic                        flush
);

  localparam int RW = $clog2(NUM_REGS);

  decode_bundle_t     dec;
  decode_bundle_t     held;
  imm_sel_t           dec_sel;
  logic [XLEN-1:0]    dec_imm;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    imm_q;
  dec_state_t         state;
  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] sb_next;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic               out_hs;
  logic               take;
  logic               dec_hazard;
  logic               held_hazard;

  assign dec     = decode_instr(in_instr);
  assign dec_sel = imm_sel_of(in_instr[6:0]);

  decode_unit_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (in_instr[31:7]),
    .imm_sel (dec_sel),
    .imm     (dec_imm)
  );

  assign in_ready  = reset && !flush &&
                     ((state == ST_IDLE) || ((state == ST_VALID) && out_ready));
  assign out_valid = (state == ST_VALID);
  assign out_hs    = out_valid && out_ready;
  assign take      = in_valid && in_ready;

  // x0 is hardwired, so a source of x0 is never considered busy.
  function automatic logic is_blocked(input decode_bundle_t d, input logic [NUM_REGS-1:0] busy);
    return (d.uses_rs1 && (d.rs1 != '0) && busy[RW'(d.rs1)]) ||
           (d.uses_rs2 && (d.rs2 != '0) && busy[RW'(d.rs2)]);
  endfunction

  // The hazard check looks at next-cycle busy bits: a same-cycle writeback
  // releases a source, and a same-cycle issue of the producer blocks it.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wb_valid)
      clr_mask[wb_rd] = 1'b1;
    if (out_hs && held.writes_rd && (held.rd != '0))
      set_mask[RW'(held.rd)] = 1'b1;
    sb_next    = (sb & ~clr_mask) | set_mask;
    sb_next[0] = 1'b0;
  end

  assign dec_hazard  = is_blocked(dec, sb_next);
  assign held_hazard = is_blocked(held, sb_next);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      sb    <= '0;
      held  <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else begin
      sb <= (flush && (FLUSH_CLEARS_SB != 0)) ? '0 : sb_next;
      if (flush) begin
        state <= ST_IDLE;
      end else if (take) begin
        held  <= dec;
        pc_q  <= in_pc;
        imm_q <= dec_imm;
        state <= dec_hazard ? ST_WAIT : ST_VALID;
      end else begin
        case (state)
          ST_WAIT:  if (!held_hazard) state <= ST_VALID;
          ST_VALID: if (out_ready)    state <= ST_IDLE;
          default:  state <= state;
        endcase
      end
    end
  end

  assign out_pc        = pc_q;
  assign out_imm       = imm_q;
  assign out_opcode    = held.opcode;
  assign out_funct3    = held.funct3;
  assign out_funct7    = held.funct7;
  assign out_rs1       = RW'(held.rs1);
  assign out_rs2       = RW'(held.rs2);
  assign out_rd        = RW'(held.rd);
  assign out_uses_rs1  = held.uses_rs1;
  assign out_uses_rs2  = held.uses_rs2;
  assign out_writes_rd = held.writes_rd;
  assign out_illegal   = held.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: two instances (flush keeps / clears the scoreboard)
// share stimulus; instance a is checked against a queue of expected bundles.
module tb_decode_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, wb_valid, flush;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  wb_rd;

  logic        in_ready, out_valid, out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  logic        b_in_ready, b_out_valid, b_uses_rs1, b_uses_rs2, b_writes_rd, b_illegal;
  logic [31:0] b_pc, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [2:0]  b_funct3;
  logic [4:0]  b_rs1, b_rs2, b_rd;

  decode_unit #(.XLEN(32), .NUM_REGS(32), .FLUSH_CLEARS_SB(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
    .out_writes_rd(out_writes_rd), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  decode_unit #(.XLEN(32), .NUM_REGS(32), .FLUSH_CLEARS_SB(1)) dut_fc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_opcode), .out_funct3(b_funct3),
    .out_funct7(b_funct7), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
    .out_imm(b_imm), .out_uses_rs1(b_uses_rs1), .out_uses_rs2(b_uses_rs2),
    .out_writes_rd(b_writes_rd), .out_illegal(b_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  flags;  // {uses_rs1, uses_rs2, writes_rd, illegal}
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_count = 0;
  int   hs_before;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.op = i[6:0]; e.f3 = '0; e.f7 = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.imm = '0; e.flags = 4'b0000;
    case (i[6:0])
      7'h33: begin
        e.f3 = i[14:12]; e.f7 = i[31:25]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.rd = i[11:7]; e.flags = 4'b1110;
      end
      7'h13, 7'h03, 7'h67: begin
        e.f3 = i[14:12]; e.rs1 = i[19:15]; e.rd = i[11:7];
        e.imm = {{20{i[31]}}, i[31:20]}; e.flags = 4'b1010;
      end
      7'h23: begin
        e.f3 = i[14:12]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; e.flags = 4'b1100;
      end
      7'h63: begin
        e.f3 = i[14:12]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; e.flags = 4'b1100;
      end
      7'h37, 7'h17: begin
        e.rd = i[11:7]; e.imm = {i[31:12], 12'h000}; e.flags = 4'b0010;
      end
      7'h6F: begin
        e.rd = i[11:7]; e.flags = 4'b0010;
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      default: e.flags = 4'b0001;
    endcase
    return e;
  endfunction

  // Output monitor: every output handshake pops and compares one expected bundle.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_output", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("pc",     64'(out_pc),     64'(mon_e.pc));
        check_val("opcode", 64'(out_opcode), 64'(mon_e.op));
        check_val("funct3", 64'(out_funct3), 64'(mon_e.f3));
        check_val("funct7", 64'(out_funct7), 64'(mon_e.f7));
        check_val("rs1",    64'(out_rs1),    64'(mon_e.rs1));
        check_val("rs2",    64'(out_rs2),    64'(mon_e.rs2));
        check_val("rd",     64'(out_rd),     64'(mon_e.rd));
        check_val("imm",    64'(out_imm),    64'(mon_e.imm));
        check_val("flags",  64'({out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal}),
                  64'(mon_e.flags));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and waits (bounded) for acceptance.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_val("accept", 64'(in_ready), 64'd1);
    if (in_ready) exp_q.push_back(model(instr, pc));
    step();
    in_valid = 1'b0;
  endtask

  task automatic writeback(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd    = r;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check_val("rst_in_ready",  64'(in_ready),  64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_pc",    64'(out_pc),    64'd0);
    check_val("rst_out_imm",   64'(out_imm),   64'd0);
    check_val("rst_out_rd",    64'(out_rd),    64'd0);
    step();
    reset = 1'b1;

    // ADDI x5,x1,-1 then dependent ADD x6,x5,x0 held until x5 retires
    send(32'hFFF08293, 32'h100);
    @(negedge clk);
    check_val("addi_lat",  64'(out_valid),    64'd1);
    check_val("addi_imm",  64'(out_imm),      64'hFFFF_FFFF);
    check_val("addi_rd",   64'(out_rd),       64'd5);
    check_val("addi_rs1",  64'(out_rs1),      64'd1);
    check_val("addi_urs2", 64'(out_uses_rs2), 64'd0);
    step();
    send(32'h00028333, 32'h104);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("raw_wait", 64'(out_valid), 64'd0);
    end
    step();
    writeback(5'd5);
    @(negedge clk);
    check_val("wb_release", 64'(out_valid), 64'd1);
    step();
    writeback(5'd6);

    // LUI x3 then BEQ x3,x0,-4 captured back-to-back: must wait for x3
    send(32'h123451B7, 32'h200);
    send(32'hFE018EE3, 32'h204);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("beq_wait",     64'(out_valid), 64'd0);
      check_val("wait_in_rdy",  64'(in_ready),  64'd0);
    end
    step();
    writeback(5'd3);
    @(negedge clk);
    check_val("beq_release", 64'(out_valid), 64'd1);
    check_val("beq_imm",     64'(out_imm),   64'hFFFF_FFFC);
    step();

    // SW x2,-8(x1) and LW x9,4(x2) back-to-back
    send(32'hFE20AC23, 32'h300);
    send(32'h00412483, 32'h304);
    @(negedge clk);
    check_val("lw_lat", 64'(out_valid), 64'd1);
    step();
    writeback(5'd9);

    // JAL x1,+2048 with downstream stalled for three cycles
    out_ready = 1'b0;
    send(32'h001000EF, 32'h400);
    hs_before = hs_count;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("jal_valid",  64'(out_valid), 64'd1);
      check_val("jal_in_rdy", 64'(in_ready),  64'd0);
      check_val("jal_imm",    64'(out_imm),   64'h0000_0800);
      check_val("jal_rd",     64'(out_rd),    64'd1);
      check_val("jal_no_hs",  64'(hs_count),  64'(hs_before));
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    check_val("jal_one_hs",  64'(hs_count),  64'(hs_before + 1));
    check_val("jal_drained", 64'(out_valid), 64'd0);
    step();
    writeback(5'd1);

    // Illegal opcode 0x7F: x31 must not become busy
    send(32'hFFFFFFFF, 32'h500);
    @(negedge clk);
    check_val("ill_flag", 64'(out_illegal), 64'd1);
    check_val("ill_imm",  64'(out_imm),     64'd0);
    step();
    send(32'h01FF83B3, 32'h504);  // ADD x7,x31,x31
    @(negedge clk);
    check_val("ill_sb_unchanged", 64'(out_valid), 64'd1);
    step();

    // Flush while ADD x8,x7,x0 waits on x7
    send(32'h00038433, 32'h600);
    @(negedge clk);
    check_val("fl_wait", 64'(out_valid), 64'd0);
    step();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00000013;
    in_pc    = 32'h604;
    @(negedge clk);
    check_val("fl_in_rdy",   64'(in_ready),   64'd0);
    check_val("fl_in_rdy_b", 64'(b_in_ready), 64'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    void'(exp_q.pop_back());
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_val("fl_idle",   64'(out_valid),   64'd0);
      check_val("fl_idle_b", 64'(b_out_valid), 64'd0);
    end
    step();
    send(32'h00038063, 32'h700);  // BEQ x7,x0,0
    @(negedge clk);
    check_val("fl_sb_kept",    64'(out_valid),   64'd0);
    check_val("fl_sb_cleared", 64'(b_out_valid), 64'd1);
    step();
    writeback(5'd7);
    @(negedge clk);
    check_val("fl_release", 64'(out_valid), 64'd1);
    step();

    // Reset while VALID with x3 busy
    send(32'h123451B7, 32'h800);
    @(negedge clk);
    check_val("lui_lat", 64'(out_valid), 64'd1);
    step();
    out_ready = 1'b0;
    send(32'hFFF08293, 32'h804);
    @(negedge clk);
    check_val("held_valid", 64'(out_valid), 64'd1);
    step();
    reset = 1'b0;
    step();
    check_val("mrst_valid",  64'(out_valid),  64'd0);
    check_val("mrst_in_rdy", 64'(in_ready),   64'd0);
    check_val("mrst_imm",    64'(out_imm),    64'd0);
    check_val("mrst_rd",     64'(out_rd),     64'd0);
    check_val("mrst_pc",     64'(out_pc),     64'd0);
    check_val("mrst_opcode", 64'(out_opcode), 64'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    void'(exp_q.pop_back());
    send(32'hFE018EE3, 32'h900);  // BEQ x3: x3 no longer busy
    @(negedge clk);
    check_val("mrst_sb_clear", 64'(out_valid), 64'd1);
    step();
    send(32'h00208033, 32'h904);  // ADD x0,x1,x2
    @(negedge clk);
    check_val("add_x0_lat", 64'(out_valid), 64'd1);
    step();
    send(32'h00000533, 32'h908);  // ADD x10,x0,x0
    @(negedge clk);
    check_val("x0_src_lat", 64'(out_valid), 64'd1);
    repeat (3) step();

    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
